// File: rtl/sa_inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: field widths, array opcodes,
// instruction field positions, descriptor payload and FSM state encodings.
package sa_inst_sequencer_pkg;

    localparam int unsigned OPCODE_BITS = 4;
    localparam int unsigned ADDR_BITS   = 16;
    localparam int unsigned CNT_BITS    = 12;
    localparam int unsigned DLY_BITS    = 8;

    // Instruction word layout seen by the systolic array: {opcode, addra, addrb}
    localparam int unsigned INST_BITS   = OPCODE_BITS + 2 * ADDR_BITS;
    localparam int unsigned OPCODE_FROM = INST_BITS - 1;
    localparam int unsigned OPCODE_TO   = 2 * ADDR_BITS;
    localparam int unsigned ADDRA_FROM  = 2 * ADDR_BITS - 1;
    localparam int unsigned ADDRA_TO    = ADDR_BITS;
    localparam int unsigned ADDRB_FROM  = ADDR_BITS - 1;
    localparam int unsigned ADDRB_TO    = 0;

    // Array opcodes
    localparam logic [OPCODE_BITS-1:0] NOP_INST          = 4'h0;
    localparam logic [OPCODE_BITS-1:0] AXI_TO_UB_INST    = 4'h1;
    localparam logic [OPCODE_BITS-1:0] UB_TO_AXI_INST    = 4'h2;
    localparam logic [OPCODE_BITS-1:0] UB_TO_WEIGHT_INST = 4'h3;
    localparam logic [OPCODE_BITS-1:0] MATMUL_INST       = 4'h4;

    // Loop descriptor; strides are two's-complement
    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [ADDR_BITS-1:0]   addra;
        logic [ADDR_BITS-1:0]   stra;
        logic [ADDR_BITS-1:0]   addrb;
        logic [ADDR_BITS-1:0]   strb;
        logic [CNT_BITS-1:0]    count;
        logic [DLY_BITS-1:0]    delay;
    } seq_desc_t;

    localparam int unsigned SEQ_DESC_BITS = $bits(seq_desc_t);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DLY   = 3'd4,
        S_NEXT  = 3'd5
    } seq_state_e;

    // Place opcode and both addresses at their instruction field positions
    function automatic logic [INST_BITS-1:0] pack_inst(
        input logic [OPCODE_BITS-1:0] op,
        input logic [ADDR_BITS-1:0]   a,
        input logic [ADDR_BITS-1:0]   b
    );
        logic [INST_BITS-1:0] inst;
        inst                        = '0;
        inst[OPCODE_FROM:OPCODE_TO] = op;
        inst[ADDRA_FROM:ADDRA_TO]   = a;
        inst[ADDRB_FROM:ADDRB_TO]   = b;
        return inst;
    endfunction

endpackage

// File: rtl/sa_inst_sequencer_if.sv
// Descriptor channel plus array instruction handshake.
//   master : sequencer side (takes descriptors, drives the array)
//   slave  : environment side (descriptor source and systolic array)
interface sa_inst_sequencer_if;
    import sa_inst_sequencer_pkg::*;

    logic                 desc_valid;
    logic                 desc_ready;
    seq_desc_t            desc;
    logic                 init_inst_pulse;
    logic [INST_BITS-1:0] instruction;
    logic                 idle_flag;
    logic                 flag;

    modport master (
        input  desc_valid, desc, idle_flag, flag,
        output desc_ready, init_inst_pulse, instruction
    );

    modport slave (
        output desc_valid, desc, idle_flag, flag,
        input  desc_ready, init_inst_pulse, instruction
    );

endinterface

// File: rtl/sa_desc_fifo.sv
// Descriptor queue: DEPTH x WIDTH synchronous FIFO with show-ahead read and flush.
//   push_i/pop_i/flush_i : write, consume head, drop all entries (flush wins)
//   wdata_i / rdata_o    : entry in / head entry out
//   ready_o / empty_o    : registered not-full / empty flags
//   empty_nxt_c          : empty flag as it will be after this edge
module sa_desc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ready_o,
    output logic             empty_o,
    output logic             empty_nxt_c
);
    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ready_q, empty_q;
    logic                do_push, do_pop;

    assign do_push = push_i & ready_q & ~flush_i;
    assign do_pop  = pop_i & ~empty_q & ~flush_i;

    // Pointer / occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset: occupancy flags gate every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign ready_o     = ready_q;
    assign empty_o     = empty_q;
    assign empty_nxt_c = (count_d == '0);

endmodule

// File: rtl/sa_inst_sequencer.sv
// Hardware loop engine for the systolic array. Expands queued loop descriptors
// into per-iteration instructions and runs the pulse / idle_flag / flag handshake.
//   clk, reset_n        : clock, async active-low reset
//   bus (master)        : descriptor channel and array instruction handshake
//   abort / err_clear   : return to idle and flush / clear sticky watchdog error
//   busy, desc_done     : activity flag, one-cycle retire pulse
//   iter_idx, error     : current iteration, sticky watchdog error
module sa_inst_sequencer
    import sa_inst_sequencer_pkg::*;
#(
    parameter int unsigned DESC_DEPTH  = 4,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset_n,
    sa_inst_sequencer_if.master bus,
    input  logic                abort,
    input  logic                err_clear,
    output logic                busy,
    output logic                desc_done,
    output logic [CNT_BITS-1:0] iter_idx,
    output logic                error
);
    localparam int unsigned WDOG_BITS = $clog2(WDOG_CYCLES + 1);

    seq_state_e             state_q, state_d;
    logic [OPCODE_BITS-1:0] op_q, op_d;
    logic [ADDR_BITS-1:0]   cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic [ADDR_BITS-1:0]   str_a_q, str_a_d, str_b_q, str_b_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d, iter_q, iter_d;
    logic [DLY_BITS-1:0]    dly_q, dly_d, dly_cnt_q, dly_cnt_d;
    logic [WDOG_BITS-1:0]   wdog_q, wdog_d;
    logic [INST_BITS-1:0]   inst_q, inst_d;
    logic                   pulse_q, done_q, done_d, busy_q, error_q, error_d;
    logic                   idle_prev_q;
    logic                   pop, push, flush, timeout;
    logic                   fifo_ready, fifo_empty, fifo_empty_nxt;
    seq_desc_t              head;

    assign push  = bus.desc_valid & fifo_ready & ~abort;
    assign flush = abort | timeout;

    sa_desc_fifo #(
        .DEPTH (DESC_DEPTH),
        .WIDTH (SEQ_DESC_BITS)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .wdata_i     (bus.desc),
        .rdata_o     (head),
        .ready_o     (fifo_ready),
        .empty_o     (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt)
    );

    // Next-state, cursor and counter logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cur_a_d   = cur_a_q;
        cur_b_d   = cur_b_q;
        str_a_d   = str_a_q;
        str_b_d   = str_b_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        dly_cnt_d = dly_cnt_q;
        iter_d    = iter_q;
        wdog_d    = wdog_q;
        inst_d    = inst_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !error_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop     = 1'b1;
                op_d    = head.opcode;
                cur_a_d = head.addra;
                cur_b_d = head.addrb;
                str_a_d = head.stra;
                str_b_d = head.strb;
                cnt_d   = head.count;
                dly_d   = head.delay;
                iter_d  = '0;
                wdog_d  = '0;
                if (head.count == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    inst_d  = pack_inst(head.opcode, head.addra, head.addrb);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d = wdog_q + WDOG_BITS'(1);
                // Array takes the instruction when idle_flag falls
                if (idle_prev_q && !bus.idle_flag) state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WDOG_BITS'(1);
                if (bus.flag) begin
                    if (dly_q == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        dly_cnt_d = dly_q - DLY_BITS'(1);
                        state_d   = S_DLY;
                    end
                end
            end
            S_DLY: begin
                if (dly_cnt_q == '0) state_d = S_NEXT;
                else                 dly_cnt_d = dly_cnt_q - DLY_BITS'(1);
            end
            S_NEXT: begin
                wdog_d  = '0;
                cur_a_d = cur_a_q + str_a_q;
                cur_b_d = cur_b_q + str_b_q;
                if (iter_q == cnt_q - CNT_BITS'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    iter_d  = iter_q + CNT_BITS'(1);
                    inst_d  = pack_inst(op_q, cur_a_d, cur_b_d);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_ISSUE || state_q == S_WAIT) &&
            wdog_q == WDOG_BITS'(WDOG_CYCLES - 1)) begin
            timeout = 1'b1;
            state_d = S_IDLE;
        end

        // Abort overrides everything, including a coincident timeout
        if (abort) begin
            timeout = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
        end

        error_d = timeout | (error_q & ~err_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            cur_a_q     <= '0;
            cur_b_q     <= '0;
            str_a_q     <= '0;
            str_b_q     <= '0;
            cnt_q       <= '0;
            dly_q       <= '0;
            dly_cnt_q   <= '0;
            iter_q      <= '0;
            wdog_q      <= '0;
            inst_q      <= '0;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            idle_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cur_a_q     <= cur_a_d;
            cur_b_q     <= cur_b_d;
            str_a_q     <= str_a_d;
            str_b_q     <= str_b_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            dly_cnt_q   <= dly_cnt_d;
            iter_q      <= iter_d;
            wdog_q      <= wdog_d;
            inst_q      <= inst_d;
            pulse_q     <= (state_d == S_ISSUE);
            done_q      <= done_d;
            busy_q      <= (state_d != S_IDLE) | ~fifo_empty_nxt;
            error_q     <= error_d;
            idle_prev_q <= bus.idle_flag;
        end
    end

    assign bus.desc_ready      = fifo_ready;
    assign bus.init_inst_pulse = pulse_q;
    assign bus.instruction     = inst_q;
    assign busy                = busy_q;
    assign desc_done           = done_q;
    assign iter_idx            = iter_q;
    assign error               = error_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Self-checking bench for sa_inst_sequencer: behavioural array model with an
// expected-instruction scoreboard, plus directed queue/delay/watchdog/abort/reset cases.
module tb_sa_inst_sequencer;
    import sa_inst_sequencer_pkg::*;

    localparam int unsigned WDOG = 4096;
    typedef logic [INST_BITS+CNT_BITS-1:0] exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                abort = 1'b0;
    logic                err_clear = 1'b0;
    logic                busy, desc_done, error;
    logic [CNT_BITS-1:0] iter_idx;

    sa_inst_sequencer_if bus();

    sa_inst_sequencer #(
        .DESC_DEPTH  (4),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .abort     (abort),
        .err_clear (err_clear),
        .busy      (busy),
        .desc_done (desc_done),
        .iter_idx  (iter_idx),
        .error     (error)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_caps = 0;
    int   done_cnt = 0;
    int   last_flag_cyc = 0;
    int   last_gap = 0;
    int   lat = 3;
    bit   stuck = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Array model: takes each pulse, drops idle_flag, flags completion after lat cycles
    initial begin : array_model
        int   phase;
        int   wait_n;
        exp_t e;
        phase = 0;
        wait_n = 0;
        bus.idle_flag = 1'b1;
        bus.flag = 1'b0;
        forever begin
            @(negedge clk);
            if (desc_done) done_cnt++;
            if (!reset_n) begin
                phase = 0;
                bus.idle_flag = 1'b1;
                bus.flag = 1'b0;
            end else begin
                case (phase)
                    0: if (bus.init_inst_pulse && !stuck) begin
                        n_caps++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_pulse", 64'(bus.init_inst_pulse), 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("inst_iter", 64'({bus.instruction, iter_idx}), 64'(e));
                        end
                        last_gap = cyc - last_flag_cyc;
                        bus.idle_flag = 1'b0;
                        wait_n = lat;
                        phase = 1;
                    end
                    1: if (wait_n == 0) begin
                        bus.flag = 1'b1;
                        last_flag_cyc = cyc;
                        phase = 2;
                    end else begin
                        wait_n--;
                    end
                    default: begin
                        bus.flag = 1'b0;
                        bus.idle_flag = 1'b1;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Offer one descriptor; on acceptance optionally queue its expected instructions
    task automatic push_desc(input logic [OPCODE_BITS-1:0] op,
                             input logic [ADDR_BITS-1:0] a, input logic [ADDR_BITS-1:0] stra,
                             input logic [ADDR_BITS-1:0] b, input logic [ADDR_BITS-1:0] strb,
                             input int cnt, input int dly, input bit track);
        logic [ADDR_BITS-1:0] ea, eb;
        tick();
        bus.desc.opcode = op;
        bus.desc.addra  = a;
        bus.desc.stra   = stra;
        bus.desc.addrb  = b;
        bus.desc.strb   = strb;
        bus.desc.count  = CNT_BITS'(cnt);
        bus.desc.delay  = DLY_BITS'(dly);
        bus.desc_valid  = 1'b1;
        for (int g = 0; g < 8000 && !bus.desc_ready; g++) tick();
        if (!bus.desc_ready) chk("push_ready_timeout", 64'(bus.desc_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
        if (track) begin
            for (int i = 0; i < cnt; i++) begin
                ea = ADDR_BITS'(a + i * stra);
                eb = ADDR_BITS'(b + i * strb);
                exp_q.push_back({op, ea, eb, CNT_BITS'(i)});
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int g = 0; g < budget && (busy || exp_q.size() != 0); g++) tick();
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        for (int g = 0; g < budget && !bus.init_inst_pulse; g++) tick();
        chk(tag, 64'(bus.init_inst_pulse), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pulse"}, 64'(bus.init_inst_pulse), 64'd0);
        chk({tag, "_inst"},  64'(bus.instruction), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_done"},  64'(desc_done), 64'd0);
        chk({tag, "_iter"},  64'(iter_idx), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_ready"}, 64'(bus.desc_ready), 64'd1);
    endtask

    initial begin : main
        int d0, c0, plen;
        bus.desc_valid = 1'b0;
        bus.desc = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) tick();

        // 256 ascending instructions on both ports
        d0 = done_cnt;
        push_desc(AXI_TO_UB_INST, 16'd0, 16'd16, 16'd0, 16'd16, 256, 0, 1'b1);
        wait_idle("asc", 8000);
        chk("asc_done", 64'(done_cnt - d0), 64'd1);
        chk("gap_dly0", 64'(last_gap), 64'd2);

        // Negative stride descending, then wrapping below zero
        d0 = done_cnt;
        push_desc(MATMUL_INST, 16'h0100, 16'd1, 16'd4080, 16'hFFF0, 256, 0, 1'b1);
        push_desc(UB_TO_AXI_INST, 16'hFFFE, 16'd1, 16'd0, 16'hFFF0, 4, 0, 1'b1);
        wait_idle("neg", 8000);
        chk("neg_done", 64'(done_cnt - d0), 64'd2);

        // Five back-to-back descriptors: one in flight, four fill the queue
        d0 = done_cnt;
        for (int i = 0; i < 5; i++)
            push_desc(OPCODE_BITS'(i + 1), ADDR_BITS'(i * 256), 16'd1,
                      ADDR_BITS'(16'h1000 + i), 16'd2, 3, 0, 1'b1);
        chk("queue_full_ready", 64'(bus.desc_ready), 64'd0);
        wait_idle("queue", 2000);
        chk("queue_done", 64'(done_cnt - d0), 64'd5);

        // Zero-count descriptor retires two cycles after push without a pulse
        c0 = n_caps;
        push_desc(MATMUL_INST, 16'd5, 16'd1, 16'd6, 16'd1, 0, 0, 1'b1);
        tick(); chk("cnt0_done_c1", 64'(desc_done), 64'd0);
        tick(); chk("cnt0_done_c2", 64'(desc_done), 64'd0);
        tick(); chk("cnt0_done_c3", 64'(desc_done), 64'd1);
        tick();
        chk("cnt0_no_pulse", 64'(n_caps - c0), 64'd0);

        // Inter-instruction delay of 3 on top of the two-cycle NEXT/ISSUE turnaround
        push_desc(UB_TO_WEIGHT_INST, 16'd0, 16'd4, 16'd8, 16'd4, 2, 3, 1'b1);
        wait_idle("dly", 500);
        chk("gap_dly3", 64'(last_gap), 64'd5);

        // Watchdog: array never accepts, second descriptor gets flushed
        stuck = 1'b1;
        d0 = done_cnt;
        push_desc(MATMUL_INST, 16'd1, 16'd1, 16'd1, 16'd1, 2, 0, 1'b0);
        push_desc(MATMUL_INST, 16'd2, 16'd1, 16'd2, 16'd1, 2, 0, 1'b0);
        wait_pulse("wdog_pulse_seen", 50);
        plen = 0;
        for (int g = 0; g < int'(WDOG) + 100 && bus.init_inst_pulse; g++) begin
            plen++;
            tick();
        end
        chk("wdog_pulse_len", 64'(plen), 64'(WDOG));
        chk("wdog_error", 64'(error), 64'd1);
        chk("wdog_flushed_busy", 64'(busy), 64'd0);
        chk("wdog_ready", 64'(bus.desc_ready), 64'd1);
        chk("wdog_no_done", 64'(done_cnt - d0), 64'd0);

        // Error blocks loads until cleared
        stuck = 1'b0;
        c0 = n_caps;
        push_desc(AXI_TO_UB_INST, 16'h0040, 16'd2, 16'h0080, 16'd2, 2, 0, 1'b1);
        repeat (10) tick();
        chk("err_blocks_load", 64'(n_caps - c0), 64'd0);
        chk("err_queue_busy", 64'(busy), 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 64'(error), 64'd0);
        wait_idle("after_clear", 200);

        // Abort while waiting on flag with two descriptors queued
        lat = 8;
        d0 = done_cnt;
        c0 = n_caps;
        push_desc(MATMUL_INST, 16'h0300, 16'd1, 16'h0400, 16'd1, 3, 0, 1'b1);
        push_desc(MATMUL_INST, 16'h0500, 16'd1, 16'h0600, 16'd1, 3, 0, 1'b0);
        push_desc(MATMUL_INST, 16'h0700, 16'd1, 16'h0800, 16'd1, 3, 0, 1'b0);
        for (int g = 0; g < 100 && n_caps == c0; g++) tick();
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_pulse", 64'(bus.init_inst_pulse), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_error", 64'(error), 64'd0);
        repeat (40) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_one_cap", 64'(n_caps - c0), 64'd1);

        // Push coinciding with abort is dropped
        bus.desc.count = CNT_BITS'(1);
        bus.desc_valid = 1'b1;
        abort = 1'b1;
        tick();
        bus.desc_valid = 1'b0;
        abort = 1'b0;
        chk("abort_push_dropped", 64'(busy), 64'd0);
        repeat (5) tick();
        chk("abort_push_no_pulse", 64'(n_caps - c0), 64'd1);
        lat = 3;

        // Async reset while the pulse is high
        stuck = 1'b1;
        push_desc(MATMUL_INST, 16'hABCD, 16'd1, 16'h1234, 16'd1, 2, 0, 1'b0);
        wait_pulse("rst_pulse_seen", 50);
        tick();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        tick();
        reset_n = 1'b1;
        stuck = 1'b0;
        repeat (2) tick();
        d0 = done_cnt;
        push_desc(UB_TO_AXI_INST, 16'h0010, 16'hFFFF, 16'h0020, 16'd3, 3, 1, 1'b1);
        wait_idle("post_rst", 300);
        chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
